// File: rtl/truth_table_checker.sv
// Sweeps all 16 minterms of {x,y,w,z}, holds each SETTLE cycles, samples a_in/f_in and compares them.
// Sweep takes 16*(SETTLE+1) busy cycles then one done cycle; start is only honoured while idle.
module truth_table_checker #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        a_in,
  input  logic        f_in,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  output logic        busy,
  output logic        done,
  output logic        equal,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_mismatch,
  output logic [15:0] table_a,
  output logic [15:0] table_f
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  minterm_q, minterm_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  mm_cnt_q, mm_cnt_d;
  logic [3:0]  first_q, first_d;
  logic [15:0] tab_a_q, tab_a_d;
  logic [15:0] tab_f_q, tab_f_d;
  logic        eq_q, eq_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      minterm_q <= 4'd0;
      cnt_q     <= 4'd0;
      mm_cnt_q  <= 5'd0;
      first_q   <= 4'd0;
      tab_a_q   <= 16'd0;
      tab_f_q   <= 16'd0;
      eq_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      minterm_q <= minterm_d;
      cnt_q     <= cnt_d;
      mm_cnt_q  <= mm_cnt_d;
      first_q   <= first_d;
      tab_a_q   <= tab_a_d;
      tab_f_q   <= tab_f_d;
      eq_q      <= eq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    minterm_d = minterm_q;
    cnt_d     = cnt_q;
    mm_cnt_d  = mm_cnt_q;
    first_d   = first_q;
    tab_a_d   = tab_a_q;
    tab_f_d   = tab_f_q;
    eq_d      = eq_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETTLE;
          minterm_d = 4'd0;
          cnt_d     = 4'd0;
          mm_cnt_d  = 5'd0;
          first_d   = 4'd0;
          tab_a_d   = 16'd0;
          tab_f_d   = 16'd0;
          eq_d      = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_SAMPLE: begin
        tab_a_d[minterm_q] = a_in;
        tab_f_d[minterm_q] = f_in;
        if (a_in != f_in) begin
          mm_cnt_d = mm_cnt_q + 5'd1;
          // count still zero means this is the lowest failing minterm
          if (mm_cnt_q == 5'd0) begin
            first_d = minterm_q;
          end
        end
        if (minterm_q == 4'd15) begin
          state_d = ST_DONE;
          eq_d    = (mm_cnt_d == 5'd0);
        end else begin
          state_d   = ST_SETTLE;
          minterm_d = minterm_q + 4'd1;
          cnt_d     = 4'd0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    done = (state_q == ST_DONE);
    if (state_q == ST_IDLE) begin
      {x, y, w, z} = 4'd0;
    end else begin
      {x, y, w, z} = minterm_q;
    end
  end

  assign equal          = eq_q;
  assign mismatch_count = mm_cnt_q;
  assign first_mismatch = first_q;
  assign table_a        = tab_a_q;
  assign table_f        = tab_f_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: two checker instances (SETTLE=1 and SETTLE=3) driven by hand-picked functions.
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start3;
  logic [1:0]  mode;
  logic        a_in, f_in, a3, f3;
  logic        x, y, w, z, busy, done, equal;
  logic        x3, y3, w3, z3, busy3, done3, equal3;
  logic [4:0]  mm_cnt, mm_cnt3;
  logic [3:0]  first, first3;
  logic [15:0] tab_a, tab_f, tab_a3, tab_f3;
  logic [15:0] pat3 = 16'hA5C3;
  logic [1:0]  ph3 = 2'd0;
  logic        ref_fn;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .f_in(f_in),
    .x(x), .y(y), .w(w), .z(z), .busy(busy), .done(done), .equal(equal),
    .mismatch_count(mm_cnt), .first_mismatch(first), .table_a(tab_a), .table_f(tab_f)
  );

  truth_table_checker #(.SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a_in(a3), .f_in(f3),
    .x(x3), .y(y3), .w(w3), .z(z3), .busy(busy3), .done(done3), .equal(equal3),
    .mismatch_count(mm_cnt3), .first_mismatch(first3), .table_a(tab_a3), .table_f(tab_f3)
  );

  // mode 0: equivalent, mode 1: fault at minterm 5, mode 2: a=1/f=0
  assign ref_fn = x & (~y | ~w | ~z);
  assign a_in   = (mode == 2'd2) ? 1'b1 : ref_fn;
  assign f_in   = (mode == 2'd2) ? 1'b0 : (ref_fn ^ ((mode == 2'd1) && ({x, y, w, z} == 4'd5)));

  // a3 only carries the true value in the cycle where the sampling edge lands
  always @(posedge clk) ph3 <= busy3 ? ph3 + 2'd1 : 2'd0;
  assign a3 = (ph3 == 2'd3) ? pat3[{x3, y3, w3, z3}] : ~pat3[{x3, y3, w3, z3}];
  assign f3 = pat3[{x3, y3, w3, z3}];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered with start already raised before an edge; returns at the negedge after done.
  task automatic measure(input bit hold, input bit pokes, output int nb, output int nd,
                         output logic seq_ok);
    nb = 0;
    nd = 0;
    seq_ok = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    while (busy && nb < 2000) begin
      if ({x, y, w, z} != 4'(nb / 2)) seq_ok = 1'b0;
      nb++;
      if (pokes) start = ((nb % 7) == 3);
      @(negedge clk);
    end
    if (!hold) start = 1'b0;
    while (done && nd < 5) begin
      if (busy) seq_ok = 1'b0;
      nd++;
      @(negedge clk);
    end
  endtask

  task automatic sweep(input string tag, input logic [1:0] md, input bit pokes);
    int nb, nd;
    logic ok;
    mode  = md;
    start = 1'b1;
    measure(1'b0, pokes, nb, nd, ok);
    chk({tag, "_busy_cycles"}, nb, 32);
    chk({tag, "_done_cycles"}, nd, 1);
    chk({tag, "_minterm_seq"}, ok, 1);
  endtask

  initial begin
    int nb, nd, wt, dc;
    logic ok;
    rst_n  = 1'b0;
    start  = 1'b0;
    start3 = 1'b0;
    mode   = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_equal", equal, 0);
    chk("rst_count", mm_cnt, 0);
    chk("rst_first", first, 0);
    chk("rst_tab_a", tab_a, 0);
    chk("rst_tab_f", tab_f, 0);
    chk("rst_xywz", {x, y, w, z}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_xywz", {x, y, w, z}, 0);

    sweep("eqv", 2'd0, 1'b0);
    chk("eqv_equal", equal, 1);
    chk("eqv_count", mm_cnt, 0);
    chk("eqv_first", first, 0);
    chk("eqv_tab_a", tab_a, 16'h7F00);
    chk("eqv_tab_f", tab_f, 16'h7F00);
    repeat (5) @(negedge clk);
    chk("hold_tab_a", tab_a, 16'h7F00);
    chk("hold_equal", equal, 1);

    sweep("fault5", 2'd1, 1'b0);
    chk("fault5_count", mm_cnt, 1);
    chk("fault5_first", first, 5);
    chk("fault5_equal", equal, 0);
    chk("fault5_xor", tab_a ^ tab_f, 16'h0020);

    sweep("all", 2'd2, 1'b0);
    chk("all_count", mm_cnt, 16);
    chk("all_first", first, 0);
    chk("all_tab_a", tab_a, 16'hFFFF);
    chk("all_tab_f", tab_f, 16'h0000);
    chk("all_equal", equal, 0);

    // abort at minterm 7 with start also high: reset must win
    mode  = 2'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wt = 0;
    while ({x, y, w, z} != 4'd7 && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    chk("abort_reach_m7", (wt < 100), 1);
    chk("abort_pre_count", mm_cnt, 7);
    dc    = done_cnt;
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_xywz", {x, y, w, z}, 0);
    chk("abort_count", mm_cnt, 0);
    chk("abort_tab_a", tab_a, 0);
    chk("abort_equal", equal, 0);
    repeat (2) @(negedge clk);
    chk("rst_over_start", busy, 0);
    rst_n = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - dc, 0);

    sweep("fresh", 2'd0, 1'b0);
    chk("fresh_equal", equal, 1);
    chk("fresh_tab_a", tab_a, 16'h7F00);

    // start held high: back-to-back sweeps separated by a single idle cycle
    mode  = 2'd0;
    start = 1'b1;
    measure(1'b1, 1'b0, nb, nd, ok);
    chk("held1_busy_cycles", nb, 32);
    chk("held1_done_cycles", nd, 1);
    chk("held_gap_busy", busy, 0);
    chk("held_gap_done", done, 0);
    measure(1'b1, 1'b0, nb, nd, ok);
    start = 1'b0;
    chk("held2_busy_cycles", nb, 32);
    chk("held2_done_cycles", nd, 1);
    chk("held2_minterm_seq", ok, 1);
    @(negedge clk);
    chk("held_stop_busy", busy, 0);

    sweep("pokes", 2'd1, 1'b1);
    chk("pokes_count", mm_cnt, 1);
    chk("pokes_first", first, 5);

    // SETTLE=3 instance
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    nb = 0;
    while (busy3 && nb < 2000) begin
      nb++;
      @(negedge clk);
    end
    chk("s3_busy_cycles", nb, 64);
    chk("s3_done", done3, 1);
    chk("s3_tab_a", tab_a3, 16'hA5C3);
    chk("s3_tab_f", tab_f3, 16'hA5C3);
    chk("s3_count", mm_cnt3, 0);
    chk("s3_equal", equal3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
